// File: rtl/matrix_inversion_ctrl.sv
// matrix_inversion_ctrl
// Sequencer around a multicycle NxN rational matrix-inversion core. It accepts
// the matrix one element per handshake in row-major order into a registered
// bank, waits CORE_LAT cycles for the core to settle, snapshots the core's
// numerator/denominator outputs, and then streams the E result pairs out.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   s_valid_i/s_ready_o  input element handshake, s_data_i element value
//   core_in_o            registered matrix to the core, element k at [k*DW +: DW]
//   core_num_i/den_i     core outputs, same packing, sampled once per job
//   m_valid_o/m_ready_i  result pair handshake
//   m_num_o, m_den_o     result pair, m_idx_o its row-major index
//   m_last_o             high with the final pair
//   singular_o           some captured denominator is zero; held for the unload
//   busy_o               high while waiting for the core or unloading
//   done_o               one-cycle pulse after the last output handshake
module matrix_inversion_ctrl #(
    parameter int unsigned N        = 5,
    parameter int unsigned DW       = 32,
    parameter int unsigned CORE_LAT = 8,
    parameter int unsigned IW       = $clog2(N * N)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [DW-1:0]       s_data_i,
    output logic [N*N*DW-1:0]   core_in_o,
    input  logic [N*N*DW-1:0]   core_num_i,
    input  logic [N*N*DW-1:0]   core_den_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [DW-1:0]       m_num_o,
    output logic [DW-1:0]       m_den_o,
    output logic [IW-1:0]       m_idx_o,
    output logic                m_last_o,
    output logic                singular_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int unsigned   E       = N * N;
    localparam int unsigned   LW      = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(E - 1);
    localparam logic [LW-1:0] LatInit = LW'(CORE_LAT - 1);

    typedef enum logic [1:0] {StLoad, StWait, StUnload} state_e;

    state_e state_q, state_d;

    logic [IW-1:0] load_cnt_q, load_cnt_d;
    logic [IW-1:0] out_cnt_q, out_cnt_d;
    logic [IW-1:0] out_nxt;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;

    logic [DW-1:0] core_in_q  [E];
    logic [DW-1:0] snap_num_q [E];
    logic [DW-1:0] snap_den_q [E];

    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_num_q, m_num_d;
    logic [DW-1:0] m_den_q, m_den_d;
    logic          singular_q, singular_d;
    logic          done_q, done_d;

    logic s_hs, m_hs, last_in, last_out, capture, any_zero;

    assign s_hs     = s_valid_i && s_ready_q;
    assign m_hs     = m_valid_q && m_ready_i;
    assign last_in  = s_hs && (load_cnt_q == LastIdx);
    assign last_out = m_hs && (out_cnt_q == LastIdx);
    assign capture  = (state_q == StWait) && (lat_cnt_q == '0);
    assign out_nxt  = out_cnt_q + 1'b1;

    for (genvar g = 0; g < E; g++) begin : g_pack
        assign core_in_o[g*DW +: DW] = core_in_q[g];
    end

    always_comb begin
        any_zero = 1'b0;
        for (int k = 0; k < E; k++) begin
            if (core_den_i[k*DW +: DW] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:   if (last_in)  state_d = StWait;
            StWait:   if (capture)  state_d = StUnload;
            StUnload: if (last_out) state_d = StLoad;
            default:  state_d = StLoad;
        endcase
    end

    // Counter and registered-output next values
    always_comb begin
        load_cnt_d = load_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        out_cnt_d  = out_cnt_q;
        m_valid_d  = m_valid_q;
        m_num_d    = m_num_q;
        m_den_d    = m_den_q;
        singular_d = singular_q;
        done_d     = 1'b0;
        // Registered ready follows the state we are about to be in.
        s_ready_d  = (state_d == StLoad);
        unique case (state_q)
            StLoad: begin
                if (s_hs) begin
                    load_cnt_d = last_in ? '0 : load_cnt_q + 1'b1;
                    if (last_in) lat_cnt_d = LatInit;
                end
            end
            StWait: begin
                if (capture) begin
                    singular_d = any_zero;
                    out_cnt_d  = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            StUnload: begin
                if (!m_valid_q) begin
                    // First UNLOAD cycle: present pair 0 from the snapshot.
                    m_valid_d = 1'b1;
                    m_num_d   = snap_num_q[out_cnt_q];
                    m_den_d   = snap_den_q[out_cnt_q];
                end else if (last_out) begin
                    m_valid_d  = 1'b0;
                    out_cnt_d  = '0;
                    singular_d = 1'b0;
                    done_d     = 1'b1;
                end else if (m_hs) begin
                    out_cnt_d = out_nxt;
                    m_num_d   = snap_num_q[out_nxt];
                    m_den_d   = snap_den_q[out_nxt];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_cnt_q <= '0;
            lat_cnt_q  <= '0;
            out_cnt_q  <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_num_q    <= '0;
            m_den_q    <= '0;
            singular_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            load_cnt_q <= load_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            out_cnt_q  <= out_cnt_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            m_num_q    <= m_num_d;
            m_den_q    <= m_den_d;
            singular_q <= singular_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < E; k++) begin
                core_in_q[k]  <= '0;
                snap_num_q[k] <= '0;
                snap_den_q[k] <= '0;
            end
        end else begin
            if (s_hs) begin
                core_in_q[load_cnt_q] <= s_data_i;
            end
            if (capture) begin
                for (int k = 0; k < E; k++) begin
                    snap_num_q[k] <= core_num_i[k*DW +: DW];
                    snap_den_q[k] <= core_den_i[k*DW +: DW];
                end
            end
        end
    end

    assign s_ready_o  = s_ready_q;
    assign m_valid_o  = m_valid_q;
    assign m_num_o    = m_num_q;
    assign m_den_o    = m_den_q;
    assign m_idx_o    = out_cnt_q;
    assign m_last_o   = m_valid_q && (out_cnt_q == LastIdx);
    assign singular_o = singular_q;
    assign busy_o     = (state_q != StLoad);
    assign done_o     = done_q;

endmodule

// File: doc/matrix_inversion_ctrl.md
Name: matrix_inversion_ctrl

Overview:
Sequencer wrapped around the combinational/multicycle 5x5 rational matrix-inversion core. It collects a matrix one element per handshake in row-major order and presents it as a stable registered bank to the core. It waits a fixed settle latency, snapshots the core's numerator/denominator outputs, and streams the 25 result pairs out over a valid/ready interface. It also flags a singular result, meaning any denominator equals zero.

Parameters:
N, 5, matrix dimension; element count E = N*N
DW, 32, element width (numerator, denominator, input)
CORE_LAT, 8, cycles from last element loaded to valid core outputs; legal range >= 1
IW, $clog2(N*N), element index width (5 for N=5)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input element valid
s_ready  out  1  controller accepts element
s_data  in  DW  input element, row-major (a11, a12 … a55)
core_in  out  E*DW  registered matrix to core; element k at [k*DW +: DW]
core_num  in  E*DW  core numerator outputs, same packing
core_den  in  E*DW  core denominator outputs, same packing
m_valid  out  1  result pair valid
m_ready  in  1  downstream accepts pair
m_num  out  DW  result numerator
m_den  out  DW  result denominator
m_idx  out  IW  row-major index of the current pair, 0..E-1
m_last  out  1  high with index E-1
singular  out  1  some captured den == 0; held for the whole unload
busy  out  1  high in WAIT and UNLOAD
done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset (asynchronous, rst_n low) values:
  - state=LOAD; load_cnt=0; lat_cnt=0; out_cnt=0.
  - core_in, snapshot registers, m_num, m_den, m_idx all 0.
  - s_ready=0, m_valid=0, m_last=0, singular=0, busy=0, done=0.
  - Reset mid-operation discards any partial matrix or result. After rst_n deasserts, the next job starts fresh at a11.
- LOAD state:
  - s_ready=1 (registered; rises the first clock after reset release).
  - On s_valid&&s_ready: core_in[load_cnt]<=s_data, and load_cnt increments.
  - On the handshake with load_cnt==E-1: load_cnt<=0, lat_cnt<=CORE_LAT-1, go to WAIT, and s_ready drops the same edge.
  - s_valid without s_ready is ignored; no elements are lost or duplicated.
- WAIT state:
  - core_in held constant; s_ready=0; lat_cnt decrements each cycle.
  - When lat_cnt==0: capture all core_num/core_den into snapshot registers and set singular = OR over k of (core_den[k]==0). Go to UNLOAD with out_cnt=0.
  - Total: exactly CORE_LAT cycles in WAIT.
- UNLOAD state:
  - m_valid=1; m_num/m_den = snapshot[out_cnt]; m_idx=out_cnt; m_last=(out_cnt==E-1).
  - Outputs are stable while m_valid&&!m_ready (no change under stall).
  - On handshake: out_cnt increments.
  - On the handshake with m_last: m_valid<=0, done<=1 for one cycle, singular<=0, go to LOAD; s_ready<=1 the same edge.
  - A singular result is still streamed; downstream decides what to do with it.
- Throughput and latency:
  - Zero-bubble accept: one element per cycle while s_valid is held.
  - One pair per cycle while m_ready is held.
  - Last input handshake to first m_valid = CORE_LAT+1 cycles.
- Core interaction: core_num/core_den are sampled only at the capture edge. Core changes at any other time have no effect.
- Simultaneous events: s_valid during WAIT/UNLOAD is not accepted (s_ready=0). Input and output phases never overlap.
- Widths: no arithmetic on data. Counters are IW bits and wrap only through the explicit E-1 checks.

Test Plan:
- Load/unload basic:
  - Stimulus: reset; feed 25 elements with s_valid held; rows are 1,1,1,1,1 / 11,12,11,11,11 / 13,13,14,13,13 / 7,7,7,8,7 / 3,3,3,3,4. Stub core returns num=in+100, den=1. m_ready=1.
  - Required: core_in element 6 (a22) = 12; m_valid rises exactly 9 cycles after the 25th handshake; 25 pairs with idx 0..24 and m_num[6]=112; m_last on idx 24; done pulses once; singular=0.
- Output backpressure:
  - Stimulus: toggle m_ready 1/0 every cycle.
  - Required: each pair is held stable while stalled; 25 distinct pairs in order; done only after the idx-24 handshake.
- Input gaps:
  - Stimulus: s_valid asserted on alternate cycles; s_valid kept high throughout WAIT/UNLOAD.
  - Required: exactly 25 elements latched; s_ready=0 outside LOAD; no extra element absorbed.
- Singular flag:
  - Stimulus: stub sets den[12]=0.
  - Required: singular=1 from the first m_valid until done; m_den at idx 12 = 0; singular=0 after done.
- Reset mid-operation:
  - Stimulus: assert rst_n low after 10 elements loaded, and again at idx 5 of an unload.
  - Required: all outputs take reset values immediately (async); the following full job loads from a11 and matches the expected results.
- Back-to-back jobs:
  - Stimulus: start the second matrix immediately after done.
  - Required: s_ready=1 the cycle after the last output handshake; second results reflect the second snapshot only.
